// File: rtl/pipeline_result_aggregator_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pipeline_result_aggregator_pkg
//  Brief   : Shared FSM encoding and tree-depth helpers for the aggregator.
//  Revision: 1.0
// ============================================================================
package pipeline_result_aggregator_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_GRAB = 2'd1,
        ST_TREE = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Tree depth: max(1, clog2(n)); a single pipe still gets one stage.
    function automatic int lvl_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Operand width after a given number of pairwise adder levels.
    function automatic int lvl_width(input int base_w, input int lvl);
        return base_w + lvl;
    endfunction

endpackage : pipeline_result_aggregator_pkg
`default_nettype wire

// File: rtl/pipeline_result_aggregator_if.sv
`default_nettype none
// ============================================================================
//  Module  : pipeline_result_aggregator_if
//  Brief   : Pipe-side and collector-side signal bundle of the aggregator.
//  Revision: 1.0
// ============================================================================
interface pipeline_result_aggregator_if
    import pipeline_result_aggregator_pkg::*;
#(
    parameter int NUM_PIPES = 4,
    parameter int SUM_W     = 51,
    parameter int CNT_W     = 16,
    parameter int ACT_W     = 2
);
    localparam int LVL = lvl_of(NUM_PIPES);

    logic [NUM_PIPES-1:0]                  pipeAvail;
    logic [NUM_PIPES*SUM_W-1:0]            pipeSums;
    logic [NUM_PIPES*CNT_W-1:0]            pipeCounts;
    logic [NUM_PIPES-1:0]                  pipeEcc;
    logic [NUM_PIPES*ACT_W-1:0]            pipeActivity;
    logic [NUM_PIPES-1:0]                  enableMask;
    logic [NUM_PIPES-1:0]                  pipeGrab;
    logic                                  resultValid;
    logic                                  resultReady;
    logic [lvl_width(SUM_W, LVL)-1:0]      resultSum;
    logic [lvl_width(CNT_W, LVL)-1:0]      resultCount;
    logic                                  eccClear;
    logic                                  eccStatus;
    logic [lvl_width(ACT_W, LVL)-1:0]      activityMeasure;
    logic                                  busy;

    modport master (
        output pipeAvail, pipeSums, pipeCounts, pipeEcc, pipeActivity,
               enableMask, resultReady, eccClear,
        input  pipeGrab, resultValid, resultSum, resultCount, eccStatus,
               activityMeasure, busy
    );

    modport slave (
        input  pipeAvail, pipeSums, pipeCounts, pipeEcc, pipeActivity,
               enableMask, resultReady, eccClear,
        output pipeGrab, resultValid, resultSum, resultCount, eccStatus,
               activityMeasure, busy
    );

endinterface : pipeline_result_aggregator_if
`default_nettype wire

// File: rtl/pipeline_result_aggregator_adder_tree.sv
`default_nettype none
// ============================================================================
//  Module  : result_adder_tree
//  Brief   : Registered pairwise adder tree, zero-padded to a power of two.
//  Revision: 1.0
// ============================================================================
module result_adder_tree
    import pipeline_result_aggregator_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    localparam int LVL = lvl_of(N),
    localparam int OW  = lvl_width(W, LVL)
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic [N*W-1:0] i_data,
    output logic      [OW-1:0]  o_sum
);
    localparam int P = 1 << LVL;

    // Missing leaves read as zero, so an odd leftover simply passes through.
    logic [P*W-1:0] w_leaf;
    assign w_leaf = (P*W)'(i_data);

    for (genvar l = 0; l < LVL; l++) begin : g_level
        localparam int NODES = P >> (l + 1);
        localparam int WI    = lvl_width(W, l);
        localparam int WO    = lvl_width(W, l + 1);

        logic [2*NODES*WI-1:0] w_in;
        logic [NODES*WO-1:0]   r_sum;

        if (l == 0) begin : g_first
            assign w_in = w_leaf;
        end else begin : g_next
            assign w_in = g_level[l-1].r_sum;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum <= '0;
            end else begin
                for (int k = 0; k < NODES; k++) begin
                    r_sum[k*WO +: WO] <= WO'(w_in[(2*k)*WI +: WI])
                                       + WO'(w_in[(2*k+1)*WI +: WI]);
                end
            end
        end
    end

    assign o_sum = g_level[LVL-1].r_sum;

endmodule : result_adder_tree
`default_nettype wire

// File: rtl/pipeline_result_aggregator.sv
`default_nettype none
// ============================================================================
//  Module  : pipeline_result_aggregator
//  Brief   : Grabs masked per-pipe sum/count results, reduces them through a
//            registered tree and holds one result for the collector.
//  Revision: 1.0
// ============================================================================
module pipeline_result_aggregator
    import pipeline_result_aggregator_pkg::*;
#(
    parameter int NUM_PIPES = 4,
    parameter int SUM_W     = 51,
    parameter int CNT_W     = 16,
    parameter int ACT_W     = 2
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    pipeline_result_aggregator_if.slave  bus
);
    localparam int LVL   = lvl_of(NUM_PIPES);
    localparam int CTR_W = $clog2(LVL + 1);
    localparam int OSW   = lvl_width(SUM_W, LVL);
    localparam int OCW   = lvl_width(CNT_W, LVL);
    localparam int OAW   = lvl_width(ACT_W, LVL);

    state_t                       r_state;
    logic [NUM_PIPES-1:0]         r_mask;
    logic [NUM_PIPES-1:0]         r_grab;
    logic                         r_valid;
    logic                         r_busy;
    logic                         r_ecc;
    logic [CTR_W-1:0]             r_ctr;
    logic [NUM_PIPES*SUM_W-1:0]   r_cap_sums;
    logic [NUM_PIPES*CNT_W-1:0]   r_cap_cnts;
    logic [NUM_PIPES*ACT_W-1:0]   r_act_in;

    logic [NUM_PIPES*SUM_W-1:0]   w_sums_masked;
    logic [NUM_PIPES*CNT_W-1:0]   w_cnts_masked;
    logic [OSW-1:0]               w_tree_sum;
    logic [OCW-1:0]               w_tree_cnt;
    logic [OAW-1:0]               w_tree_act;
    logic                         w_start;
    logic                         w_ecc_set;

    // Disabled pipes count as ready; an empty mask never starts a round.
    assign w_start   = (|bus.enableMask) && (&(bus.pipeAvail | ~bus.enableMask));
    assign w_ecc_set = |(bus.pipeEcc & bus.enableMask);

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_mask
        assign w_sums_masked[i*SUM_W +: SUM_W] =
            r_mask[i] ? bus.pipeSums[i*SUM_W +: SUM_W] : '0;
        assign w_cnts_masked[i*CNT_W +: CNT_W] =
            r_mask[i] ? bus.pipeCounts[i*CNT_W +: CNT_W] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_WAIT;
            r_mask     <= '0;
            r_grab     <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_ctr      <= '0;
            r_cap_sums <= '0;
            r_cap_cnts <= '0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (w_start) begin
                        r_mask  <= bus.enableMask;
                        r_grab  <= bus.enableMask;
                        r_busy  <= 1'b1;
                        r_state <= ST_GRAB;
                    end
                end
                ST_GRAB: begin
                    // Capture on the same edge that ends the grab pulse.
                    r_grab     <= '0;
                    r_cap_sums <= w_sums_masked;
                    r_cap_cnts <= w_cnts_masked;
                    r_ctr      <= CTR_W'(LVL - 1);
                    r_state    <= ST_TREE;
                end
                ST_TREE: begin
                    if (r_ctr == '0) begin
                        r_valid <= 1'b1;
                        r_state <= ST_HOLD;
                    end else begin
                        r_ctr <= r_ctr - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.resultReady) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                default: begin
                    r_state <= ST_WAIT;
                end
            endcase
        end
    end

    // A clear beats a same-cycle set; a set on the following cycle re-arms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ecc <= 1'b0;
        end else if (bus.eccClear) begin
            r_ecc <= 1'b0;
        end else if (w_ecc_set) begin
            r_ecc <= 1'b1;
        end
    end

    // Input stage ahead of the activity tree gives it a fixed LVL+1 latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_in <= '0;
        end else begin
            r_act_in <= bus.pipeActivity;
        end
    end

    result_adder_tree #(.N(NUM_PIPES), .W(SUM_W)) u_sum_tree (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (r_cap_sums),
        .o_sum  (w_tree_sum)
    );

    result_adder_tree #(.N(NUM_PIPES), .W(CNT_W)) u_cnt_tree (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (r_cap_cnts),
        .o_sum  (w_tree_cnt)
    );

    result_adder_tree #(.N(NUM_PIPES), .W(ACT_W)) u_act_tree (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (r_act_in),
        .o_sum  (w_tree_act)
    );

    assign bus.pipeGrab        = r_grab;
    assign bus.resultValid     = r_valid;
    assign bus.resultSum       = w_tree_sum;
    assign bus.resultCount     = w_tree_cnt;
    assign bus.eccStatus       = r_ecc;
    assign bus.activityMeasure = w_tree_act;
    assign bus.busy            = r_busy;

endmodule : pipeline_result_aggregator
`default_nettype wire

// File: tb/tb_pipeline_result_aggregator.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pipeline_result_aggregator
//  Brief   : Scoreboard bench for the 4-pipe and 5-pipe aggregator builds.
//  Revision: 1.0
// ============================================================================
module tb_pipeline_result_aggregator;

    localparam int LVL4 = 2;
    localparam int LVL5 = 3;

    logic clk = 1'b0;
    logic rst_n4;
    logic rst_n5;
    always #5 clk = ~clk;

    pipeline_result_aggregator_if #(.NUM_PIPES(4)) if4 ();
    pipeline_result_aggregator_if #(.NUM_PIPES(5)) if5 ();

    pipeline_result_aggregator #(.NUM_PIPES(4)) dut4 (.clk(clk), .rst_n(rst_n4), .bus(if4.slave));
    pipeline_result_aggregator #(.NUM_PIPES(5)) dut5 (.clk(clk), .rst_n(rst_n5), .bus(if5.slave));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [63:0] q_grab4[$], q_sum4[$], q_cnt4[$];
    logic [63:0] q_grab5[$], q_sum5[$], q_cnt5[$];
    int   grab_cyc4 = 0, grab_cyc5 = 0;
    logic prev_v4 = 1'b0, prev_v5 = 1'b0;
    logic [63:0] junk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout/unexpected required=event", name);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (if4.pipeGrab != '0) begin
            if (q_grab4.size() == 0) fail_now("grab4_unexpected");
            else begin
                chk("grab4", 64'(if4.pipeGrab), q_grab4.pop_front());
                grab_cyc4 = cyc;
            end
        end
        if (if4.resultValid) begin
            if (!prev_v4) chk("latency4", 64'(cyc - grab_cyc4), 64'(LVL4 + 1));
            if (q_sum4.size() == 0) fail_now("result4_unexpected");
            else begin
                chk("sum4", 64'(if4.resultSum), q_sum4[0]);
                chk("count4", 64'(if4.resultCount), q_cnt4[0]);
                if (if4.resultReady) begin
                    junk = q_sum4.pop_front();
                    junk = q_cnt4.pop_front();
                end
            end
        end
        prev_v4 = if4.resultValid;
    end

    always @(negedge clk) begin
        if (if5.pipeGrab != '0) begin
            if (q_grab5.size() == 0) fail_now("grab5_unexpected");
            else begin
                chk("grab5", 64'(if5.pipeGrab), q_grab5.pop_front());
                grab_cyc5 = cyc;
            end
        end
        if (if5.resultValid) begin
            if (!prev_v5) chk("latency5", 64'(cyc - grab_cyc5), 64'(LVL5 + 1));
            if (q_sum5.size() == 0) fail_now("result5_unexpected");
            else begin
                chk("sum5", 64'(if5.resultSum), q_sum5[0]);
                chk("count5", 64'(if5.resultCount), q_cnt5[0]);
                if (if5.resultReady) begin
                    junk = q_sum5.pop_front();
                    junk = q_cnt5.pop_front();
                end
            end
        end
        prev_v5 = if5.resultValid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grab4();
        int n = 0;
        do begin @(negedge clk); n++; end while (if4.pipeGrab == '0 && n < 20);
        if (n >= 20) fail_now("grab4_timeout");
    endtask

    task automatic finish_txn4(input int hold);
        int n = 0;
        wait_grab4();
        @(posedge clk); #1 if4.pipeAvail = '0;
        while (!if4.resultValid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) fail_now("valid4_timeout");
        repeat (hold) @(negedge clk);
        @(posedge clk); #1 if4.resultReady = 1'b1;
        @(posedge clk); #1 if4.resultReady = 1'b0;
        chk("valid4_drop", 64'(if4.resultValid), 64'd0);
        chk("busy4_drop", 64'(if4.busy), 64'd0);
    endtask

    task automatic finish_txn5();
        int n = 0;
        do begin @(negedge clk); n++; end while (if5.pipeGrab == '0 && n < 20);
        if (n >= 20) fail_now("grab5_timeout");
        @(posedge clk); #1 if5.pipeAvail = '0;
        n = 0;
        while (!if5.resultValid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) fail_now("valid5_timeout");
        @(posedge clk); #1 if5.resultReady = 1'b1;
        @(posedge clk); #1 if5.resultReady = 1'b0;
        chk("valid5_drop", 64'(if5.resultValid), 64'd0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n4 = 1'b0; rst_n5 = 1'b0;
        if4.pipeAvail = '0; if4.pipeSums = '0; if4.pipeCounts = '0; if4.pipeEcc = '0;
        if4.pipeActivity = '0; if4.enableMask = '0; if4.resultReady = 1'b0; if4.eccClear = 1'b0;
        if5.pipeAvail = '0; if5.pipeSums = '0; if5.pipeCounts = '0; if5.pipeEcc = '0;
        if5.pipeActivity = '0; if5.enableMask = '0; if5.resultReady = 1'b0; if5.eccClear = 1'b0;
        tick(2);
        chk("rst_valid", 64'(if4.resultValid), 64'd0);
        chk("rst_grab", 64'(if4.pipeGrab), 64'd0);
        chk("rst_sum", 64'(if4.resultSum), 64'd0);
        chk("rst_busy_ecc_act", {if4.busy, if4.eccStatus, 60'(if4.activityMeasure)}, 64'd0);
        rst_n4 = 1'b1; rst_n5 = 1'b1;
        tick(2);

        // Full mask, result held 20 cycles before acceptance.
        if4.pipeSums   = {51'd4, 51'd3, 51'd2, 51'd1};
        if4.pipeCounts = {16'd40, 16'd30, 16'd20, 16'd10};
        if4.enableMask = 4'hF;
        q_grab4.push_back(64'hF); q_sum4.push_back(64'd10); q_cnt4.push_back(64'd100);
        if4.pipeAvail  = 4'hF;
        finish_txn4(20);
        tick(2);

        // Pipe 3 not available: stall, then exclude it via the mask.
        if4.pipeSums   = {51'd100, 51'd7, 51'd6, 51'd5};
        if4.pipeCounts = {16'd50, 16'd3, 16'd2, 16'd1};
        if4.pipeAvail  = 4'b0111;
        if4.resultReady = 1'b1;
        tick(5);
        chk("stall_busy", 64'(if4.busy), 64'd0);
        chk("stall_valid", 64'(if4.resultValid), 64'd0);
        if4.resultReady = 1'b0;
        q_grab4.push_back(64'h7); q_sum4.push_back(64'd18); q_cnt4.push_back(64'd6);
        if4.enableMask = 4'h7;
        finish_txn4(0);
        tick(2);

        // Sticky ECC with live mask and clear priority.
        if4.enableMask = 4'b0100; if4.pipeEcc = 4'b0100;
        tick(1); if4.pipeEcc = '0;
        chk("ecc_set", 64'(if4.eccStatus), 64'd1);
        tick(3);
        chk("ecc_sticky", 64'(if4.eccStatus), 64'd1);
        if4.eccClear = 1'b1; tick(1); if4.eccClear = 1'b0;
        chk("ecc_clear", 64'(if4.eccStatus), 64'd0);
        if4.enableMask = 4'b0011; if4.pipeEcc = 4'b0100;
        tick(2); if4.pipeEcc = '0;
        chk("ecc_masked", 64'(if4.eccStatus), 64'd0);
        if4.enableMask = 4'b0100; if4.pipeEcc = 4'b0100; if4.eccClear = 1'b1;
        tick(1);
        chk("ecc_clear_wins", 64'(if4.eccStatus), 64'd0);
        if4.eccClear = 1'b0;
        tick(1);
        chk("ecc_rearm", 64'(if4.eccStatus), 64'd1);
        if4.pipeEcc = '0; if4.eccClear = 1'b1; tick(1); if4.eccClear = 1'b0;

        // Activity tree: latency LVL+1 = 3.
        if4.pipeActivity = {2'd3, 2'd3, 2'd3, 2'd3};
        tick(2);
        chk("act_early", 64'(if4.activityMeasure), 64'd0);
        tick(1);
        chk("act_12", 64'(if4.activityMeasure), 64'd12);
        if4.pipeActivity = {2'd0, 2'd3, 2'd2, 2'd1};
        tick(3);
        chk("act_6", 64'(if4.activityMeasure), 64'd6);
        if4.pipeActivity = '0;
        tick(3);

        // Five pipes, all-ones sums: exact wide result, three levels.
        if5.pipeSums   = {5{51'h7_FFFF_FFFF_FFFF}};
        if5.pipeCounts = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        if5.enableMask = 5'h1F;
        q_grab5.push_back(64'h1F); q_sum5.push_back(64'd11258999068426235); q_cnt5.push_back(64'd15);
        if5.pipeAvail  = 5'h1F;
        finish_txn5();
        tick(2);

        // Reset during TREE aborts; held avail then yields a fresh round.
        if4.enableMask = 4'hF;
        if4.pipeSums   = {51'd1, 51'd1, 51'd1, 51'd1};
        if4.pipeCounts = {16'd9, 16'd9, 16'd9, 16'd9};
        q_grab4.push_back(64'hF); q_sum4.push_back(64'd4); q_cnt4.push_back(64'd36);
        if4.pipeAvail  = 4'hF;
        wait_grab4();
        @(posedge clk); #1 rst_n4 = 1'b0;
        #1;
        chk("abort_valid", 64'(if4.resultValid), 64'd0);
        chk("abort_busy", 64'(if4.busy), 64'd0);
        chk("abort_sum_cnt", {8'(if4.resultSum), 8'(if4.resultCount), 48'd0}, 64'd0);
        chk("abort_grab", 64'(if4.pipeGrab), 64'd0);
        q_sum4.delete(); q_cnt4.delete();
        if4.pipeSums   = {51'd10, 51'd9, 51'd8, 51'd7};
        if4.pipeCounts = {16'd1, 16'd1, 16'd1, 16'd1};
        q_grab4.push_back(64'hF); q_sum4.push_back(64'd34); q_cnt4.push_back(64'd4);
        tick(2);
        rst_n4 = 1'b1;
        finish_txn4(2);
        tick(3);

        chk("pending4", 64'(q_grab4.size() + q_sum4.size()), 64'd0);
        chk("pending5", 64'(q_grab5.size() + q_sum5.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule : tb_pipeline_result_aggregator
`default_nettype wire
